// File: rtl/store_lane_packer.sv
// Store lane packer: turns a right-justified byte/half/word store into one or two
// word-aligned memory write beats with lane-positioned data and byte enables.
module store_lane_packer #(
    parameter bit ALLOW_SPLIT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [1:0]  req_size,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BEAT1 = 2'b01,
        BEAT2 = 2'b10
    } state_t;

    state_t      state_r, state_s;
    logic        mem_valid_r, mem_valid_s;
    logic [31:0] mem_addr_r, mem_addr_s;
    logic [31:0] mem_wdata_r, mem_wdata_s;
    logic [3:0]  mem_be_r, mem_be_s;
    logic        err_r, err_s;
    logic [31:0] b2_addr_r, b2_addr_s;
    logic [31:0] b2_wdata_r, b2_wdata_s;
    logic [3:0]  b2_be_r, b2_be_s;

    logic [1:0]  off_s;
    logic [3:0]  mask_s;
    logic [63:0] sh_s;
    logic [7:0]  bm_s;
    logic        illegal_s;
    logic        split_s;
    logic        reject_s;
    logic        accept_s;
    logic [31:0] base_addr_s;

    assign req_ready = (state_r == IDLE) & ~rst;
    assign accept_s  = req_valid & req_ready;
    assign busy      = (state_r != IDLE);
    assign mem_valid = mem_valid_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_be    = mem_be_r;
    assign err       = err_r;

    // Lane placement over a two-word window; the upper word is the spill-over beat.
    always_comb begin
        off_s = req_addr[1:0];
        case (req_size)
            2'b00:   mask_s = 4'b0001;
            2'b01:   mask_s = 4'b0011;
            2'b10:   mask_s = 4'b1111;
            default: mask_s = 4'b0000;
        endcase
        sh_s        = {32'd0, req_data} << {off_s, 3'b000};
        bm_s        = {4'b0000, mask_s} << off_s;
        illegal_s   = (req_size == 2'b11);
        split_s     = (bm_s[7:4] != 4'b0000);
        reject_s    = illegal_s | (split_s & (ALLOW_SPLIT == 1'b0));
        base_addr_s = {req_addr[31:2], 2'b00};
    end

    // Next-state and next-output logic for the beat sequencer.
    always_comb begin
        state_s     = state_r;
        mem_valid_s = mem_valid_r;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        mem_be_s    = mem_be_r;
        err_s       = 1'b0;
        b2_addr_s   = b2_addr_r;
        b2_wdata_s  = b2_wdata_r;
        b2_be_s     = b2_be_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (reject_s) begin
                        err_s = 1'b1;
                    end else begin
                        state_s     = BEAT1;
                        mem_valid_s = 1'b1;
                        mem_addr_s  = base_addr_s;
                        mem_wdata_s = sh_s[31:0];
                        mem_be_s    = bm_s[3:0];
                        b2_addr_s   = base_addr_s + 32'd4;
                        b2_wdata_s  = sh_s[63:32];
                        b2_be_s     = bm_s[7:4];
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            BEAT1: begin
                if (mem_ready) begin
                    // A non-empty second enable mask is what marks a split store.
                    if (b2_be_r != 4'b0000) begin
                        state_s     = BEAT2;
                        mem_addr_s  = b2_addr_r;
                        mem_wdata_s = b2_wdata_r;
                        mem_be_s    = b2_be_r;
                    end else begin
                        state_s     = IDLE;
                        mem_valid_s = 1'b0;
                        mem_be_s    = 4'b0000;
                    end
                end else begin
                    state_s = BEAT1;
                end
            end
            BEAT2: begin
                if (mem_ready) begin
                    state_s     = IDLE;
                    mem_valid_s = 1'b0;
                    mem_be_s    = 4'b0000;
                end else begin
                    state_s = BEAT2;
                end
            end
            default: begin
                state_s     = IDLE;
                mem_valid_s = 1'b0;
                mem_be_s    = 4'b0000;
            end
        endcase
    end

    // State and output registers; reset drops any pending beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            mem_valid_r <= 1'b0;
            mem_addr_r  <= 32'd0;
            mem_wdata_r <= 32'd0;
            mem_be_r    <= 4'b0000;
            err_r       <= 1'b0;
            b2_addr_r   <= 32'd0;
            b2_wdata_r  <= 32'd0;
            b2_be_r     <= 4'b0000;
        end else begin
            state_r     <= state_s;
            mem_valid_r <= mem_valid_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            mem_be_r    <= mem_be_s;
            err_r       <= err_s;
            b2_addr_r   <= b2_addr_s;
            b2_wdata_r  <= b2_wdata_s;
            b2_be_r     <= b2_be_s;
        end
    end

endmodule

// File: tb/tb_store_lane_packer.sv
// Scoreboard bench for store_lane_packer: byte-window reference model feeds an expected
// queue; a negedge monitor checks every beat and error pulse the DUT presents.
module tb_store_lane_packer;

    typedef struct packed {
        logic        is_err;
        logic        more;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_data = 32'd0;
    logic [1:0]  req_size = 2'b00;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        busy;
    logic        err;

    logic        ns_req_valid = 1'b0;
    logic        ns_req_ready;
    logic [31:0] ns_req_addr = 32'd0;
    logic [31:0] ns_req_data = 32'd0;
    logic [1:0]  ns_req_size = 2'b00;
    logic        ns_mem_valid;
    logic [31:0] ns_mem_addr;
    logic [31:0] ns_mem_wdata;
    logic [3:0]  ns_mem_be;
    logic        ns_busy;
    logic        ns_err;

    int   n_checks = 0;
    int   n_pass = 0;
    bit   rand_mode = 1'b0;
    exp_t sb[$];

    always #5 clk = ~clk;

    store_lane_packer #(.ALLOW_SPLIT(1'b1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .busy(busy), .err(err)
    );

    store_lane_packer #(.ALLOW_SPLIT(1'b0)) dut_ns (
        .clk(clk), .rst(rst), .req_valid(ns_req_valid), .req_ready(ns_req_ready),
        .req_addr(ns_req_addr), .req_data(ns_req_data), .req_size(ns_req_size),
        .mem_valid(ns_mem_valid), .mem_ready(1'b1), .mem_addr(ns_mem_addr),
        .mem_wdata(ns_mem_wdata), .mem_be(ns_mem_be), .busy(ns_busy), .err(ns_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference: walk the 8-byte window starting at the word of addr; window byte k
    // holds data byte (k-off) and is enabled when that byte is within the store size.
    function automatic void model(input logic [31:0] addr, input logic [31:0] data,
                                  input logic [1:0] size, output exp_t b1, output exp_t b2);
        int off;
        int nbytes;
        int j;
        logic [7:0] d;
        logic       en;
        off    = int'(addr[1:0]);
        nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        b1 = '0;
        b2 = '0;
        b1.addr = {addr[31:2], 2'b00};
        b2.addr = b1.addr + 32'd4;
        for (int k = 0; k < 8; k++) begin
            j = k - off;
            if (j >= 0 && j < 4) begin
                d  = data[8*j +: 8];
                en = (j < nbytes);
            end else begin
                d  = 8'h00;
                en = 1'b0;
            end
            if (k < 4) begin
                b1.wdata[8*k +: 8] = d;
                b1.be[k] = en;
            end else begin
                b2.wdata[8*(k-4) +: 8] = d;
                b2.be[k-4] = en;
            end
        end
        b1.more = (b2.be != 4'b0000);
        b1.is_err = (size == 2'b11);
    endfunction

    task automatic push_expect(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
        exp_t b1, b2;
        model(addr, data, size, b1, b2);
        if (b1.is_err) begin
            sb.push_back(b1);
        end else begin
            sb.push_back(b1);
            if (b1.more) sb.push_back(b2);
        end
    endtask

    // Present a request until accepted; returns #1 into the cycle after the accepting edge.
    task automatic send(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
        int t = 0;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_addr  = addr;
        req_data  = data;
        req_size  = size;
        while (!req_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (!req_ready) begin
            chk("req_accept_timeout", 64'd0, 64'd1);
            req_valid = 1'b0;
        end else begin
            push_expect(addr, data, size);
            @(posedge clk); #1;
            req_valid = 1'b0;
            req_addr  = $urandom;
            req_data  = $urandom;
            req_size  = 2'($urandom_range(0, 3));
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (rand_mode) mem_ready = ($urandom_range(0, 3) != 0);
    end

    bit          hold = 1'b0;
    bit          expect_cont = 1'b0;
    logic [31:0] held_addr, held_wdata;
    logic [3:0]  held_be;

    // Monitor: compare every completed beat and error pulse against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold = 1'b0;
            expect_cont = 1'b0;
        end else begin
            if (expect_cont) begin
                chk("no_bubble", 64'(mem_valid), 64'd1);
                expect_cont = 1'b0;
            end
            if (hold && mem_valid) begin
                chk("hold_addr", 64'(mem_addr), 64'(held_addr));
                chk("hold_wdata", 64'(mem_wdata), 64'(held_wdata));
                chk("hold_be", 64'(mem_be), 64'(held_be));
            end
            if (err) begin
                chk("err_with_valid", 64'(mem_valid), 64'd0);
                if (sb.size() == 0) chk("unexpected_err", 64'd1, 64'd0);
                else begin
                    e = sb.pop_front();
                    chk("err_expected", 64'(e.is_err), 64'd1);
                end
            end
            if (mem_valid && mem_ready) begin
                if (sb.size() == 0) chk("unexpected_beat", 64'(mem_addr), 64'hDEAD);
                else begin
                    e = sb.pop_front();
                    chk("beat_not_err", 64'(e.is_err), 64'd0);
                    chk("beat_addr", 64'(mem_addr), 64'(e.addr));
                    chk("beat_wdata", 64'(mem_wdata), 64'(e.wdata));
                    chk("beat_be", 64'(mem_be), 64'(e.be));
                    expect_cont = e.more;
                end
            end
            hold       = mem_valid && !mem_ready;
            held_addr  = mem_addr;
            held_wdata = mem_wdata;
            held_be    = mem_be;
        end
    end

    initial begin
        exp_t n1, n2;
        int   t;
        logic [31:0] a;
        logic [1:0]  sz;
        int   r;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_valid", 64'(mem_valid), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_mem_be", 64'(mem_be), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        rst = 1'b0;

        // Aligned-in-word halfword with ready high: beat at T+1, ready again at T+2.
        mem_ready = 1'b1;
        send(32'h0000_1002, 32'h0000_BEEF, 2'b01);
        chk("lat_beat_t1", 64'(mem_valid), 64'd1);
        chk("lat_busy", 64'(busy), 64'd1);
        @(posedge clk); #1;
        chk("lat_ready_t2", 64'(req_ready), 64'd1);
        chk("lat_valid_clear", 64'(mem_valid), 64'd0);

        // Misaligned word split into two beats.
        send(32'h0000_2003, 32'h1122_3344, 2'b10);
        repeat (3) @(posedge clk);

        // Byte store stalled for three cycles.
        mem_ready = 1'b0;
        send(32'h0000_0005, 32'h0000_00A5, 2'b00);
        for (int i = 0; i < 3; i++) begin
            chk("stall_req_ready", 64'(req_ready), 64'd0);
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        chk("stall_req_ready_last", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        chk("stall_ready_after", 64'(req_ready), 64'd1);

        // Illegal size produces a single error pulse.
        send(32'h0000_0100, 32'h1234_5678, 2'b11);
        chk("err_pulse", 64'(err), 64'd1);
        chk("err_no_valid", 64'(mem_valid), 64'd0);
        chk("err_ready_next", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        chk("err_one_cycle", 64'(err), 64'd0);

        // Wrap from the top word to address zero.
        send(32'hFFFF_FFFF, 32'h0000_CAFE, 2'b01);
        repeat (3) @(posedge clk);

        // Reset while the second beat is stalled.
        mem_ready = 1'b0;
        send(32'h0000_2003, 32'h1122_3344, 2'b10);
        mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        chk("b2_pending_be", 64'(mem_be), 64'h7);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_valid", 64'(mem_valid), 64'd0);
        chk("mid_rst_be", 64'(mem_be), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_ready", 64'(req_ready), 64'd0);
        sb.delete();
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 64'(req_ready), 64'd1);
        mem_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("no_stale_beat", 64'(mem_valid), 64'd0);

        // Split disabled: misaligned word and half are rejected, in-word byte passes.
        @(posedge clk); #1;
        ns_req_valid = 1'b1; ns_req_addr = 32'h0000_3001; ns_req_data = 32'h1122_3344; ns_req_size = 2'b10;
        chk("ns_ready", 64'(ns_req_ready), 64'd1);
        @(posedge clk); #1;
        ns_req_valid = 1'b0;
        chk("ns_err_pulse", 64'(ns_err), 64'd1);
        chk("ns_err_no_valid", 64'(ns_mem_valid), 64'd0);
        chk("ns_ready_next", 64'(ns_req_ready), 64'd1);
        ns_req_valid = 1'b1; ns_req_addr = 32'h0000_3003; ns_req_size = 2'b01;
        @(posedge clk); #1;
        ns_req_valid = 1'b0;
        chk("ns_half_err", 64'(ns_err), 64'd1);
        chk("ns_half_no_valid", 64'(ns_mem_valid), 64'd0);
        ns_req_valid = 1'b1; ns_req_addr = 32'h0000_3001; ns_req_data = 32'h1122_33A5; ns_req_size = 2'b00;
        @(posedge clk); #1;
        ns_req_valid = 1'b0;
        model(32'h0000_3001, 32'h1122_33A5, 2'b00, n1, n2);
        chk("ns_byte_err", 64'(ns_err), 64'd0);
        chk("ns_byte_valid", 64'(ns_mem_valid), 64'd1);
        chk("ns_byte_addr", 64'(ns_mem_addr), 64'(n1.addr));
        chk("ns_byte_wdata", 64'(ns_mem_wdata), 64'(n1.wdata));
        chk("ns_byte_be", 64'(ns_mem_be), 64'(n1.be));
        @(posedge clk); #1;
        chk("ns_byte_done", 64'(ns_mem_valid), 64'd0);

        // Randomized traffic with random backpressure.
        rand_mode = 1'b1;
        for (int n = 0; n < 60; n++) begin
            r  = int'($urandom_range(0, 7));
            sz = (r == 7) ? 2'b11 : 2'(r % 3);
            a  = $urandom;
            if ($urandom_range(0, 3) == 0) a = {30'h3FFF_FFFF, a[1:0]};
            send(a, $urandom, sz);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        t = 0;
        while (sb.size() != 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
